sha256_hash_state: RTL and testbench
====================================

// Module: sha256_hash_state
// PURPOSE
//  Parametrised SHA-2 chaining-value register bank: holds all NUM_WORDS H words,
//  loads the SHA-256 or SHA-224 IV on start, and adds each compressed block's
//  working variables (a..h) into H mod 2^WORD_W. Supports multi-block messages
//  with a valid/ready input and holds the final digest until acknowledged.
//  Sits between the round core and the nonce/compare logic.
// PARAMETERS
//  WORD_W     32  width of one H word; IV table entries truncated to low WORD_W bits
//  NUM_WORDS  8   number of H words, legal range 1..8; word i takes IV table entry i
//  CNT_W      16  width of blk_count
// PORTS
//  clk           in   1                  rising-edge clock
//  rst           in   1                  asynchronous, active-high reset
//  start         in   1                  pulse: load IV, clear count, enter ACTIVE
//  mode_224      in   1                  sampled on start: 0 = SHA-256 IV, 1 = SHA-224 IV
//  work_valid    in   1                  work_in/work_last valid
//  work_ready    out  1                  block accepts work; high only in ACTIVE
//  work_in       in   NUM_WORDS*WORD_W   a..h of finished block; a at MSB word
//  work_last     in   1                  this block is the final block of the message
//  digest        out  NUM_WORDS*WORD_W   current H; H0 at MSB word
//  digest_valid  out  1                  digest is final; held until digest_ack
//  digest_ack    in   1                  consumer took digest
//  blk_count     out  CNT_W              blocks accumulated since start, saturating
//  busy          out  1                  state != IDLE
// BEHAVIOUR
//  - Reset (async): H = SHA-256 IV (H0 6a09e667 ... H7 5be0cd19), state IDLE,
//    work_ready 0, digest_valid 0, blk_count 0, busy 0.
//  - FSM IDLE -> ACTIVE on start. ACTIVE -> DONE on accept with work_last.
//    DONE -> IDLE on digest_ack. start in any state -> ACTIVE.
//  - SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
//  - Accept = work_valid & work_ready. On accept at edge N, each H_i <= H_i + work_i,
//    carry discarded per word, with no carry between words. blk_count increments,
//    saturating at all-ones. The new digest is visible after edge N.
//  - work_last accepted at edge N: the state is DONE and digest_valid = 1 after edge N,
//    so the updated digest and digest_valid appear together. work_ready = 0 in DONE.
//  - DONE: H, blk_count and digest_valid hold. The edge with digest_ack clears
//    digest_valid. H is not reloaded until the next start.
//  - digest_ack outside DONE is ignored.
//  - start has priority over a simultaneous accept: that work is dropped, not added.
//    H = IV of sampled mode_224, blk_count = 0, digest_valid = 0.
//  - start while in DONE discards the held digest without an ack.
//  - work_valid while IDLE or DONE: no effect; the producer holds its data.
//  - Reset mid-message: immediate IDLE with SHA-256 IV; partial message is lost.
//  - Only H, the state and blk_count are registered. work_ready, busy and digest are
//    direct functions of the registers, with no combinational path from inputs.
// TESTING
//  1. Reset -> digest = 6a09e667..5be0cd19, digest_valid 0, work_ready 0, busy 0.
//  2. start (mode_224=0), work_in all 0, work_last=1 -> digest = SHA-256 IV,
//     digest_valid 1 one edge after accept, blk_count 1.
//     digest_ack -> IDLE, digest_valid 0.
//  3. start (mode_224=1), 3 blocks of all ffffffff, last on third ->
//     H7 = befa4fa4 - 3 = befa4fa1, blk_count 3.
//     Apply work_valid stalls between blocks -> no extra adds.
//  4. Wrap: start, H7 work word a41f32e7 -> H7 = 00000000.
//     Other words unaffected, with no cross-word carry.
//  5. start asserted on the same edge as an accept, and again while in DONE ->
//     work dropped, H = IV, blk_count 0, digest_valid 0.
//  6. Assert rst mid-message, between edges -> outputs take reset values immediately.
//     CNT_W=2 with 5 blocks -> blk_count saturates at 3.

Source files
------------

// File: rtl/sha256_hash_state.sv
// sha256_hash_state: SHA-2 chaining-value register bank with IV load, per-block add and held digest.
//  Holds NUM_WORDS H words. start loads the SHA-256 or SHA-224 IV, clears the
//  block count and enters ACTIVE. Each accepted block adds its a..h words into
//  H modulo 2^WORD_W. After the last block, the state moves to DONE and the
//  digest is held until digest_ack.
//  Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, mode_224   load IV (mode_224 selects the SHA-224 IV), enter ACTIVE
//   work_valid/ready  block handshake; work_in carries a..h with a at the MSB word
//   work_last         the accepted block ends the message
//   digest            current H with H0 at the MSB word
//   digest_valid      final digest held; digest_ack releases it
//   blk_count         saturating count of blocks accumulated since start
//   busy              state is not IDLE
module sha256_hash_state #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode_224,
    input  logic                        work_valid,
    output logic                        work_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] work_in,
    input  logic                        work_last,
    output logic [NUM_WORDS*WORD_W-1:0] digest,
    output logic                        digest_valid,
    input  logic                        digest_ack,
    output logic [CNT_W-1:0]            blk_count,
    output logic                        busy
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    state_t            state_q, state_d;
    logic [WORD_W-1:0] h_q [NUM_WORDS];
    logic [WORD_W-1:0] h_d [NUM_WORDS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    function automatic logic [WORD_W-1:0] iv_word(input logic m, input logic [2:0] i);
        return WORD_W'(m ? IV224[i] : IV256[i]);
    endfunction

    assign accept = work_valid && (state_q == ACTIVE);

    // start wins over a same-edge accept, so the colliding block is dropped
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            for (int i = 0; i < NUM_WORDS; i++) h_d[i] = iv_word(mode_224, 3'(i));
        end else if (accept) begin
            for (int i = 0; i < NUM_WORDS; i++)
                h_d[i] = h_q[i] + work_in[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            state_d = work_last ? DONE : ACTIVE;
        end else if (state_q == DONE && digest_ack) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= iv_word(1'b0, 3'(i));
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= h_d[i];
        end
    end

    assign work_ready   = (state_q == ACTIVE);
    assign digest_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign blk_count    = cnt_q;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_dig
        assign digest[(NUM_WORDS-1-g)*WORD_W +: WORD_W] = h_q[g];
    end
endmodule

// File: tb/tb_sha256_hash_state.sv
// tb_sha256_hash_state: directed and random checks of the hash state bank against a word-level model.
module tb_sha256_hash_state;
    logic         clk = 0, rst = 0, start = 0, mode_224 = 0;
    logic         work_valid = 0, work_last = 0, digest_ack = 0;
    logic [255:0] work_in = '0;
    logic         work_ready, digest_valid, busy;
    logic [255:0] digest;
    logic [15:0]  blk_count;
    logic         work_ready2, digest_valid2, busy2;
    logic [255:0] digest2;
    logic [1:0]   blk_count2;

    sha256_hash_state dut (
        .clk(clk), .rst(rst), .start(start), .mode_224(mode_224),
        .work_valid(work_valid), .work_ready(work_ready), .work_in(work_in),
        .work_last(work_last), .digest(digest), .digest_valid(digest_valid),
        .digest_ack(digest_ack), .blk_count(blk_count), .busy(busy)
    );

    sha256_hash_state #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .mode_224(mode_224),
        .work_valid(work_valid), .work_ready(work_ready2), .work_in(work_in),
        .work_last(work_last), .digest(digest2), .digest_valid(digest_valid2),
        .digest_ack(digest_ack), .blk_count(blk_count2), .busy(busy2)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;

    logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    // Model: H words, message phase flags and two saturating counts
    logic [31:0] m_h [8];
    bit          m_active, m_done;
    int          m_cnt, m_cnt2;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] m_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[255-32*i -: 32] = m_h[i];
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_h[i] = iv256[i];
        m_active = 0; m_done = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        if (start) begin
            for (int i = 0; i < 8; i++) m_h[i] = mode_224 ? iv224[i] : iv256[i];
            m_active = 1; m_done = 0; m_cnt = 0; m_cnt2 = 0;
        end else if (m_active && work_valid) begin
            for (int i = 0; i < 8; i++) m_h[i] = m_h[i] + work_in[255-32*i -: 32];
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            if (work_last) begin m_active = 0; m_done = 1; end
        end else if (m_done && digest_ack) begin
            m_done = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " digest"}, digest, m_digest());
        chk({tag, " digest_valid"}, 256'(digest_valid), 256'(m_done));
        chk({tag, " work_ready"}, 256'(work_ready), 256'(m_active));
        chk({tag, " busy"}, 256'(busy), 256'(m_active || m_done));
        chk({tag, " blk_count"}, 256'(blk_count), 256'(m_cnt));
        chk({tag, " blk_count2"}, 256'(blk_count2), 256'(m_cnt2));
        chk({tag, " digest2"}, digest2, m_digest());
    endtask

    task automatic drive(input bit s, input bit m, input bit v, input logic [255:0] w,
                         input bit l, input bit a);
        start = s; mode_224 = m; work_valid = v; work_in = w; work_last = l; digest_ack = a;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #2 rst = 1;
        #1 model_reset();
        check_all("reset_async");
        @(negedge clk) rst = 0;
        check_all("reset_release");

        drive(1, 0, 0, '0, 0, 0); step("t2_start");
        drive(0, 0, 1, '0, 1, 0); step("t2_last");
        chk("t2_digest_iv", digest, {iv256[0], iv256[1], iv256[2], iv256[3],
                                     iv256[4], iv256[5], iv256[6], iv256[7]});
        drive(0, 0, 0, '0, 0, 0); step("t2_hold");
        drive(0, 0, 0, '0, 0, 1); step("t2_ack");
        drive(0, 0, 0, '0, 0, 0); step("t2_idle");

        drive(1, 1, 0, '0, 0, 0); step("t3_start");
        for (int b = 0; b < 3; b++) begin
            drive(0, 0, 1, {256{1'b1}}, b == 2, 0); step("t3_blk");
            drive(0, 0, 0, {256{1'b1}}, 0, 0); step("t3_stall");
        end
        chk("t3_h7", 256'(digest[31:0]), 256'(32'hbefa4fa1));
        chk("t3_cnt", 256'(blk_count), 256'd3);
        drive(0, 0, 0, '0, 0, 1); step("t3_ack");

        drive(1, 0, 0, '0, 0, 0); step("t4_start");
        drive(0, 0, 1, {192'd0, 32'hffffffff, 32'ha41f32e7}, 1, 0); step("t4_wrap");
        chk("t4_h7_zero", 256'(digest[31:0]), 256'd0);
        chk("t4_h5", 256'(digest[95:64]), 256'(32'h9b05688c));
        drive(0, 0, 0, '0, 0, 1); step("t4_ack");

        drive(1, 1, 0, '0, 0, 0); step("t5_start");
        drive(0, 0, 1, rnd256(), 0, 0); step("t5_add");
        drive(1, 0, 1, rnd256(), 1, 0); step("t5_collide");
        chk("t5_cnt_zero", 256'(blk_count), 256'd0);
        drive(0, 0, 1, rnd256(), 1, 0); step("t5_to_done");
        drive(1, 1, 0, '0, 0, 0); step("t5_start_in_done");
        chk("t5_dv_zero", 256'(digest_valid), 256'd0);

        drive(0, 0, 1, rnd256(), 0, 0); step("t6_blk");
        drive(0, 0, 1, rnd256(), 0, 0); step("t6_blk");
        #2 rst = 1;
        #1 model_reset();
        check_all("t6_mid_reset");
        @(negedge clk) rst = 0;
        drive(1, 0, 0, '0, 0, 0); step("t6_start");
        for (int b = 0; b < 5; b++) begin
            drive(0, 0, 1, rnd256(), 0, 0); step("t6_sat");
        end
        chk("t6_cnt2_sat", 256'(blk_count2), 256'd3);
        chk("t6_cnt16", 256'(blk_count), 256'd5);

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                  rnd256(), $urandom_range(0, 3) == 0, $urandom_range(0, 1));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
